// File: rtl/mandel_frame_sequencer.sv
// mandel_frame_sequencer: schedules a WIDTH x HEIGHT frame over NUM_ENGINES
// mandelbrot engines. Coordinates are dispatched round-robin, each engine's
// iteration count is captured into its slot, and results retire strictly in
// raster order on a valid/ready pixel stream.

// One engine slot: FREE -> BUSY on dispatch, BUSY -> HELD when the engine's
// running flag falls, HELD -> FREE when its pixel is handed off.
module mandel_frame_slot #(
    parameter int CTRWIDTH = 10,
    parameter int XW       = 9,
    parameter int YW       = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                disp,
    input  logic                retire,
    input  logic [XW-1:0]       x_in,
    input  logic [YW-1:0]       y_in,
    input  logic                running,
    input  logic [CTRWIDTH-1:0] ctr_in,
    output logic                is_free,
    output logic                is_held,
    output logic [XW-1:0]       x_out,
    output logic [YW-1:0]       y_out,
    output logic [CTRWIDTH-1:0] ctr_out
);
    typedef enum logic [1:0] {S_FREE, S_BUSY, S_HELD} slot_t;

    slot_t               st_q, st_d;
    logic                run_prev_q;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [CTRWIDTH-1:0] hold_q, hold_d;
    logic                fall;

    // Result is valid on the 1->0 edge of the engine's running flag.
    assign fall = run_prev_q & ~running;

    // Slot transitions; a flush (abort) frees the slot whatever it holds.
    always_comb begin
        st_d   = st_q;
        x_d    = x_q;
        y_d    = y_q;
        hold_d = hold_q;
        if (flush) begin
            st_d = S_FREE;
        end else begin
            case (st_q)
                S_FREE: if (disp) begin
                    st_d = S_BUSY;
                    x_d  = x_in;
                    y_d  = y_in;
                end
                S_BUSY: if (fall) begin
                    st_d   = S_HELD;
                    hold_d = ctr_in;
                end
                S_HELD: if (retire) st_d = S_FREE;
                default: st_d = S_FREE;
            endcase
        end
    end

    // Slot state, latched coordinates, held result and the running edge detector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q       <= S_FREE;
            run_prev_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            hold_q     <= '0;
        end else begin
            st_q       <= st_d;
            run_prev_q <= running;
            x_q        <= x_d;
            y_q        <= y_d;
            hold_q     <= hold_d;
        end
    end

    assign is_free = (st_q == S_FREE);
    assign is_held = (st_q == S_HELD);
    assign x_out   = x_q;
    assign y_out   = y_q;
    assign ctr_out = hold_q;
endmodule

module mandel_frame_sequencer #(
    parameter int NUM_ENGINES = 2,
    parameter int CTRWIDTH    = 10,
    parameter int WIDTH       = 400,
    parameter int HEIGHT      = 300,
    localparam int XW         = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    localparam int YW         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            abort,
    output logic [NUM_ENGINES-1:0]          eng_run,
    output logic [XW-1:0]                   eng_x,
    output logic [YW-1:0]                   eng_y,
    input  logic [NUM_ENGINES-1:0]          eng_running,
    input  logic [NUM_ENGINES*CTRWIDTH-1:0] eng_ctr,
    output logic                            px_valid,
    input  logic                            px_ready,
    output logic [CTRWIDTH-1:0]             px_ctr,
    output logic [XW-1:0]                   px_x,
    output logic [YW-1:0]                   px_y,
    output logic                            px_last,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            reset_write_ptr
);
    localparam int PW   = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CNW  = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  dptr_q, dptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [XW-1:0]  dx_q, dx_d;
    logic [YW-1:0]  dy_q, dy_d;
    logic [CNW-1:0] dcnt_q, dcnt_d;

    logic [NUM_ENGINES-1:0]               slot_free, slot_held, slot_retire;
    logic [NUM_ENGINES-1:0][XW-1:0]       slot_x;
    logic [NUM_ENGINES-1:0][YW-1:0]       slot_y;
    logic [NUM_ENGINES-1:0][CTRWIDTH-1:0] slot_ctr;

    logic          cur_free, cur_held;
    logic          flush, disp_ok, px_fire;

    // Select the dispatch-side and retire-side slot views by pointer.
    always_comb begin
        cur_free = 1'b0;
        cur_held = 1'b0;
        px_x     = '0;
        px_y     = '0;
        px_ctr   = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (dptr_q == PW'(i)) cur_free = slot_free[i];
            if (rptr_q == PW'(i)) begin
                cur_held = slot_held[i];
                px_x     = slot_x[i];
                px_y     = slot_y[i];
                px_ctr   = slot_ctr[i];
            end
        end
    end

    // Abort cancels everything in the same cycle it is seen.
    assign flush    = abort && (state_q != IDLE);
    assign disp_ok  = (state_q == RUN) && !abort && cur_free && (dcnt_q < CNW'(NPIX));
    assign px_valid = (state_q == RUN) && !abort && cur_held;
    assign px_fire  = px_valid && px_ready;
    assign px_last  = px_valid && (px_x == XW'(WIDTH - 1)) && (px_y == YW'(HEIGHT - 1));

    assign eng_x           = dx_q;
    assign eng_y           = dy_q;
    assign busy            = (state_q != IDLE);
    assign frame_done      = (state_q == DONE);
    assign reset_write_ptr = (state_q == CLEAR);

    // One-hot dispatch pulse and per-slot retire strobes.
    always_comb begin
        eng_run     = '0;
        slot_retire = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            eng_run[i]     = disp_ok && (dptr_q == PW'(i));
            slot_retire[i] = px_fire && (rptr_q == PW'(i));
        end
    end

    // Frame FSM, raster dispatch counters and round-robin pointers.
    always_comb begin
        state_d = state_q;
        dptr_d  = dptr_q;
        rptr_d  = rptr_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            IDLE:  if (start && !abort) state_d = CLEAR;
            CLEAR: begin
                dptr_d  = '0;
                rptr_d  = '0;
                dx_d    = '0;
                dy_d    = '0;
                dcnt_d  = '0;
                state_d = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort)                  state_d = IDLE;
                else if (px_fire && px_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (disp_ok) begin
            dptr_d = (dptr_q == PW'(NUM_ENGINES - 1)) ? '0 : dptr_q + 1'b1;
            dcnt_d = dcnt_q + 1'b1;
            if (dx_q == XW'(WIDTH - 1)) begin
                dx_d = '0;
                dy_d = dy_q + 1'b1;
            end else begin
                dx_d = dx_q + 1'b1;
            end
        end
        if (px_fire) rptr_d = (rptr_q == PW'(NUM_ENGINES - 1)) ? '0 : rptr_q + 1'b1;
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dptr_q  <= '0;
            rptr_q  <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dptr_q  <= dptr_d;
            rptr_q  <= rptr_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            dcnt_q  <= dcnt_d;
        end
    end

    for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_slot
        mandel_frame_slot #(
            .CTRWIDTH (CTRWIDTH),
            .XW       (XW),
            .YW       (YW)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .disp    (eng_run[i]),
            .retire  (slot_retire[i]),
            .x_in    (dx_q),
            .y_in    (dy_q),
            .running (eng_running[i]),
            .ctr_in  (eng_ctr[i*CTRWIDTH +: CTRWIDTH]),
            .is_free (slot_free[i]),
            .is_held (slot_held[i]),
            .x_out   (slot_x[i]),
            .y_out   (slot_y[i]),
            .ctr_out (slot_ctr[i])
        );
    end
endmodule

// File: tb/tb_mandel_frame_sequencer.sv
// Bench for mandel_frame_sequencer: a 2-engine 4x2 instance (A) and a
// 1-engine 3x1 instance (B), each driven by behavioural engines with random
// latency. Expected pixels come from raster index arithmetic.
module tb_mandel_frame_sequencer;
    localparam int CW = 10;
    localparam int NA = 2, WA = 4, HA = 2;
    localparam int NB = 1, WB = 3, HB = 1;

    typedef struct {int x; int y; int ctr; bit last; int cyc;} pix_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0, fails = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A ----------------
    logic            a_start, a_abort, a_ready;
    logic [NA-1:0]   a_eng_run, a_eng_running;
    logic [1:0]      a_eng_x, a_px_x;
    logic [0:0]      a_eng_y, a_px_y;
    logic [NA*CW-1:0] a_eng_ctr;
    logic [CW-1:0]   a_px_ctr;
    logic            a_px_valid, a_px_last, a_busy, a_fd, a_rwp;

    mandel_frame_sequencer #(.NUM_ENGINES(NA), .CTRWIDTH(CW), .WIDTH(WA), .HEIGHT(HA)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
        .eng_run(a_eng_run), .eng_x(a_eng_x), .eng_y(a_eng_y),
        .eng_running(a_eng_running), .eng_ctr(a_eng_ctr),
        .px_valid(a_px_valid), .px_ready(a_ready), .px_ctr(a_px_ctr),
        .px_x(a_px_x), .px_y(a_px_y), .px_last(a_px_last), .busy(a_busy),
        .frame_done(a_fd), .reset_write_ptr(a_rwp));

    int a_lo[NA], a_hi[NA], a_rem[NA], a_pend[NA];
    int a_salt = 0;

    // Engine model A: running rises the cycle after eng_run, stays high for a
    // random latency; the count is garbage until the falling edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_eng_running <= '0;
            a_eng_ctr     <= '0;
        end else begin
            for (int i = 0; i < NA; i++) begin
                if (a_eng_running[i]) begin
                    if (a_rem[i] <= 1) begin
                        a_eng_running[i]       <= 1'b0;
                        a_eng_ctr[i*CW +: CW]  <= CW'(a_pend[i]);
                    end else a_rem[i] <= a_rem[i] - 1;
                end else if (a_eng_run[i]) begin
                    a_eng_running[i]      <= 1'b1;
                    a_rem[i]              <= int'($urandom_range(a_hi[i], a_lo[i]));
                    a_pend[i]             <= int'(a_eng_x) + WA * int'(a_eng_y) + a_salt;
                    a_eng_ctr[i*CW +: CW] <= CW'($urandom);
                end
            end
        end
    end

    pix_t a_q[$];
    int   a_rwp_n, a_fd_n, a_run_n, a_fd_cyc, a_last_cyc, a_out_max;

    // Recorder A: logs handshakes and event counts away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            a_run_n += $countones(a_eng_run);
            if (a_run_n - a_q.size() > a_out_max) a_out_max = a_run_n - a_q.size();
            if (a_px_valid && a_px_ready_w()) begin
                a_q.push_back('{int'(a_px_x), int'(a_px_y), int'(a_px_ctr), a_px_last, cyc});
                if (a_px_last) a_last_cyc = cyc;
            end
            a_rwp_n += int'(a_rwp);
            a_fd_n  += int'(a_fd);
            if (a_fd) a_fd_cyc = cyc;
        end
    end

    function automatic bit a_px_ready_w();
        return a_ready;
    endfunction

    // ---------------- DUT B ----------------
    logic            b_start, b_abort, b_ready;
    logic [NB-1:0]   b_eng_run, b_eng_running;
    logic [1:0]      b_eng_x, b_px_x;
    logic [0:0]      b_eng_y, b_px_y;
    logic [NB*CW-1:0] b_eng_ctr;
    logic [CW-1:0]   b_px_ctr;
    logic            b_px_valid, b_px_last, b_busy, b_fd, b_rwp;

    mandel_frame_sequencer #(.NUM_ENGINES(NB), .CTRWIDTH(CW), .WIDTH(WB), .HEIGHT(HB)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
        .eng_run(b_eng_run), .eng_x(b_eng_x), .eng_y(b_eng_y),
        .eng_running(b_eng_running), .eng_ctr(b_eng_ctr),
        .px_valid(b_px_valid), .px_ready(b_ready), .px_ctr(b_px_ctr),
        .px_x(b_px_x), .px_y(b_px_y), .px_last(b_px_last), .busy(b_busy),
        .frame_done(b_fd), .reset_write_ptr(b_rwp));

    int b_rem, b_pend;
    int b_salt = 0;

    // Engine model B, same contract as A.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            b_eng_running <= '0;
            b_eng_ctr     <= '0;
        end else if (b_eng_running[0]) begin
            if (b_rem <= 1) begin
                b_eng_running[0] <= 1'b0;
                b_eng_ctr        <= CW'(b_pend);
            end else b_rem <= b_rem - 1;
        end else if (b_eng_run[0]) begin
            b_eng_running[0] <= 1'b1;
            b_rem            <= int'($urandom_range(4, 1));
            b_pend           <= int'(b_eng_x) + WB * int'(b_eng_y) + b_salt;
            b_eng_ctr        <= CW'($urandom);
        end
    end

    pix_t b_q[$];
    int   b_rwp_n, b_fd_n, b_run_n, b_out_max;

    // Recorder B.
    always @(negedge clk) begin
        if (!reset) begin
            b_run_n += $countones(b_eng_run);
            if (b_run_n - b_q.size() > b_out_max) b_out_max = b_run_n - b_q.size();
            if (b_px_valid && b_ready)
                b_q.push_back('{int'(b_px_x), int'(b_px_y), int'(b_px_ctr), b_px_last, cyc});
            b_rwp_n += int'(b_rwp);
            b_fd_n  += int'(b_fd);
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_a();
        a_q.delete();
        a_rwp_n = 0; a_fd_n = 0; a_run_n = 0; a_out_max = 0;
        a_fd_cyc = -1; a_last_cyc = -100;
    endtask

    task automatic set_lat_a(input int lo0, input int hi0, input int lo1, input int hi1);
        a_lo[0] = lo0; a_hi[0] = hi0; a_lo[1] = lo1; a_hi[1] = hi1;
    endtask

    task automatic pulse_start_a();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    task automatic a_wait_done(input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            a_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            step();
            if (a_fd_n > 0) begin
                ok = 1'b1;
                break;
            end
        end
        a_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b/%b exp 0/0", a_busy, b_busy); end
        tests++; if (a_px_valid !== 1'b0 || b_px_valid !== 1'b0) begin fails++; $display("FAIL reset_px_valid got %b/%b exp 0/0", a_px_valid, b_px_valid); end
        tests++; if (a_eng_run !== '0 || b_eng_run !== '0) begin fails++; $display("FAIL reset_eng_run got %b/%b exp 0", a_eng_run, b_eng_run); end
        tests++; if ({a_fd, a_rwp, a_px_last} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b exp 000", {a_fd, a_rwp, a_px_last}); end
        tests++; if ({a_px_x, a_px_y, a_px_ctr, a_eng_x, a_eng_y} !== '0) begin fails++; $display("FAIL reset_data got %h exp 0", {a_px_x, a_px_y, a_px_ctr, a_eng_x, a_eng_y}); end
        repeat (3) step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bit ok;
        clr_a(); a_salt = 0; set_lat_a(3, 3, 3, 3);
        pulse_start_a();
        tests++; if (a_rwp !== 1'b1) begin fails++; $display("FAIL basic_rwp_timing got %b exp 1", a_rwp); end
        a_wait_done(1'b0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_timeout got no frame_done exp frame_done"); end
        tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after got %b exp 0", a_busy); end
        repeat (3) step();
        tests++; if (a_q.size() != WA * HA) begin fails++; $display("FAIL basic_count got %0d exp %0d", a_q.size(), WA * HA); end
        foreach (a_q[k]) begin
            tests++;
            if (a_q[k].x != k % WA || a_q[k].y != k / WA || a_q[k].ctr != k || a_q[k].last != (k == WA * HA - 1)) begin
                fails++; $display("FAIL basic_pix%0d got x%0d y%0d c%0d l%0d exp x%0d y%0d c%0d", k, a_q[k].x, a_q[k].y, a_q[k].ctr, a_q[k].last, k % WA, k / WA, k);
            end
        end
        tests++; if (a_rwp_n != 1 || a_fd_n != 1) begin fails++; $display("FAIL basic_pulse_counts got rwp%0d fd%0d exp 1 1", a_rwp_n, a_fd_n); end
        tests++; if (a_fd_cyc != a_last_cyc + 1) begin fails++; $display("FAIL basic_done_timing got cyc%0d exp %0d", a_fd_cyc, a_last_cyc + 1); end
    endtask

    task automatic test_order();
        bit ok;
        clr_a(); a_salt = int'($urandom_range(1023, 0)); set_lat_a(9, 9, 2, 2);
        pulse_start_a();
        a_wait_done(1'b0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL order_timeout got no frame_done exp frame_done"); end
        tests++; if (a_q.size() != WA * HA) begin fails++; $display("FAIL order_count got %0d exp %0d", a_q.size(), WA * HA); end
        foreach (a_q[k]) begin
            tests++;
            if (a_q[k].x != k % WA || a_q[k].y != k / WA || a_q[k].ctr != (k + a_salt) % 1024) begin
                fails++; $display("FAIL order_pix%0d got x%0d y%0d c%0d exp x%0d y%0d c%0d", k, a_q[k].x, a_q[k].y, a_q[k].ctr, k % WA, k / WA, (k + a_salt) % 1024);
            end
        end
        tests++; if (a_out_max > NA) begin fails++; $display("FAIL order_outstanding got %0d exp <=%0d", a_out_max, NA); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int sx, sy, sc, runs;
        clr_a(); a_salt = int'($urandom_range(1023, 0)); set_lat_a(1, 4, 1, 4);
        pulse_start_a();
        for (int i = 0; i < 200 && !(a_q.size() >= 2 && a_px_valid); i++) step();
        a_ready = 1'b0;
        tests++; if (a_px_valid !== 1'b1) begin fails++; $display("FAIL bp_reach got valid %b exp 1", a_px_valid); end
        sx = int'(a_px_x); sy = int'(a_px_y); sc = int'(a_px_ctr);
        runs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            tests++;
            if (a_px_valid !== 1'b1 || int'(a_px_x) != sx || int'(a_px_y) != sy || int'(a_px_ctr) != sc) begin
                fails++; $display("FAIL bp_stable%0d got v%b x%0d y%0d c%0d exp v1 x%0d y%0d c%0d", i, a_px_valid, a_px_x, a_px_y, a_px_ctr, sx, sy, sc);
            end
            if (i >= 12) runs += $countones(a_eng_run);
        end
        tests++; if (runs != 0) begin fails++; $display("FAIL bp_no_dispatch got %0d eng_run exp 0", runs); end
        a_wait_done(1'b0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL bp_timeout got no frame_done exp frame_done"); end
        tests++; if (a_q.size() != WA * HA) begin fails++; $display("FAIL bp_count got %0d exp %0d", a_q.size(), WA * HA); end
        foreach (a_q[k]) begin
            tests++;
            if (a_q[k].x != k % WA || a_q[k].y != k / WA || a_q[k].ctr != (k + a_salt) % 1024) begin
                fails++; $display("FAIL bp_pix%0d got x%0d y%0d c%0d exp x%0d y%0d c%0d", k, a_q[k].x, a_q[k].y, a_q[k].ctr, k % WA, k / WA, (k + a_salt) % 1024);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        clr_a(); a_salt = 5; set_lat_a(8, 8, 8, 8);
        pulse_start_a();
        for (int i = 0; i < 50 && a_run_n < 2; i++) step();
        tests++; if (a_run_n != 2) begin fails++; $display("FAIL abort_dispatch got %0d exp 2", a_run_n); end
        a_abort = 1'b1; a_start = 1'b1;
        step();
        a_abort = 1'b0; a_start = 1'b0;
        tests++; if (a_busy !== 1'b0 || a_px_valid !== 1'b0) begin fails++; $display("FAIL abort_idle got busy%b valid%b exp 0 0", a_busy, a_px_valid); end
        repeat (30) step();
        tests++; if (a_q.size() != 0 || a_fd_n != 0) begin fails++; $display("FAIL abort_quiet got px%0d fd%0d exp 0 0", a_q.size(), a_fd_n); end
        tests++; if (a_run_n != 2 || a_rwp_n != 1) begin fails++; $display("FAIL abort_no_run got run%0d rwp%0d exp 2 1", a_run_n, a_rwp_n); end
        clr_a(); a_salt = int'($urandom_range(1023, 0)); set_lat_a(2, 2, 2, 2);
        pulse_start_a();
        a_wait_done(1'b0, ok);
        tests++; if (!ok || a_q.size() != WA * HA) begin fails++; $display("FAIL abort_restart got ok%0d px%0d exp 1 %0d", ok, a_q.size(), WA * HA); end
        foreach (a_q[k]) begin
            tests++;
            if (a_q[k].x != k % WA || a_q[k].y != k / WA || a_q[k].ctr != (k + a_salt) % 1024) begin
                fails++; $display("FAIL abort_pix%0d got x%0d y%0d c%0d exp x%0d y%0d c%0d", k, a_q[k].x, a_q[k].y, a_q[k].ctr, k % WA, k / WA, (k + a_salt) % 1024);
            end
        end
    endtask

    task automatic test_start_busy();
        bit ok;
        clr_a(); a_salt = int'($urandom_range(1023, 0)); set_lat_a(1, 3, 1, 3);
        pulse_start_a();
        for (int i = 0; i < 200 && a_q.size() < 3; i++) step();
        pulse_start_a();
        a_wait_done(1'b0, ok);
        repeat (4) step();
        tests++; if (!ok || a_rwp_n != 1 || a_fd_n != 1) begin fails++; $display("FAIL start_busy got ok%0d rwp%0d fd%0d exp 1 1 1", ok, a_rwp_n, a_fd_n); end
        tests++; if (a_q.size() != WA * HA) begin fails++; $display("FAIL start_busy_count got %0d exp %0d", a_q.size(), WA * HA); end
    endtask

    task automatic test_random();
        bit ok;
        for (int f = 0; f < 4; f++) begin
            clr_a(); a_salt = int'($urandom_range(1023, 0));
            set_lat_a(1, int'($urandom_range(8, 1)), 1, int'($urandom_range(8, 1)));
            pulse_start_a();
            a_wait_done(1'b1, ok);
            repeat (2) step();
            tests++; if (!ok || a_q.size() != WA * HA || a_fd_n != 1) begin fails++; $display("FAIL rand%0d_frame got ok%0d px%0d fd%0d exp 1 %0d 1", f, ok, a_q.size(), a_fd_n, WA * HA); end
            foreach (a_q[k]) begin
                tests++;
                if (a_q[k].x != k % WA || a_q[k].y != k / WA || a_q[k].ctr != (k + a_salt) % 1024 || a_q[k].last != (k == WA * HA - 1)) begin
                    fails++; $display("FAIL rand%0d_pix%0d got x%0d y%0d c%0d l%0d exp x%0d y%0d c%0d", f, k, a_q[k].x, a_q[k].y, a_q[k].ctr, a_q[k].last, k % WA, k / WA, (k + a_salt) % 1024);
                end
            end
            tests++; if (a_out_max > NA) begin fails++; $display("FAIL rand%0d_outstanding got %0d exp <=%0d", f, a_out_max, NA); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr_a(); a_salt = 0; set_lat_a(2, 2, 2, 2);
        pulse_start_a();
        for (int i = 0; i < 200 && a_q.size() < 3; i++) step();
        #2 reset = 1'b1;
        #1;
        tests++; if (a_busy !== 1'b0 || a_px_valid !== 1'b0 || a_eng_run !== '0) begin fails++; $display("FAIL rstmid_ctrl got busy%b valid%b run%b exp 0", a_busy, a_px_valid, a_eng_run); end
        tests++; if ({a_px_x, a_px_y, a_px_ctr, a_eng_x, a_eng_y, a_fd, a_rwp, a_px_last} !== '0) begin fails++; $display("FAIL rstmid_data got %h exp 0", {a_px_x, a_px_y, a_px_ctr, a_eng_x, a_eng_y}); end
        #3 reset = 1'b0;
        step();
        clr_a();
        pulse_start_a();
        a_wait_done(1'b0, ok);
        tests++; if (!ok || a_q.size() != WA * HA || a_q[0].x != 0 || a_q[0].ctr != 0) begin fails++; $display("FAIL rstmid_recover got ok%0d px%0d exp 1 %0d", ok, a_q.size(), WA * HA); end
    endtask

    task automatic test_single();
        bit ok;
        for (int f = 0; f < 2; f++) begin
            b_q.delete(); b_rwp_n = 0; b_fd_n = 0; b_run_n = 0; b_out_max = 0;
            b_salt = int'($urandom_range(1023, 0));
            b_start = 1'b1; step(); b_start = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 500; i++) begin
                b_ready = 1'($urandom_range(1, 0));
                step();
                if (b_fd_n > 0) begin ok = 1'b1; break; end
            end
            b_ready = 1'b1;
            step();
            tests++; if (!ok || b_rwp_n != 1 || b_fd_n != 1 || b_busy !== 1'b0) begin fails++; $display("FAIL single%0d_frame got ok%0d rwp%0d fd%0d busy%b exp 1 1 1 0", f, ok, b_rwp_n, b_fd_n, b_busy); end
            tests++; if (b_q.size() != WB * HB) begin fails++; $display("FAIL single%0d_count got %0d exp %0d", f, b_q.size(), WB * HB); end
            foreach (b_q[k]) begin
                tests++;
                if (b_q[k].x != k || b_q[k].y != 0 || b_q[k].ctr != (k + b_salt) % 1024 || b_q[k].last != (k == WB * HB - 1)) begin
                    fails++; $display("FAIL single%0d_pix%0d got x%0d y%0d c%0d l%0d exp x%0d y0 c%0d", f, k, b_q[k].x, b_q[k].y, b_q[k].ctr, b_q[k].last, k, (k + b_salt) % 1024);
                end
            end
            tests++; if (b_out_max > 1) begin fails++; $display("FAIL single%0d_sequential got %0d outstanding exp <=1", f, b_out_max); end
        end
    endtask

    initial begin
        a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1;
        b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < NA; i++) begin a_lo[i] = 1; a_hi[i] = 1; a_rem[i] = 0; a_pend[i] = 0; end
        b_rem = 0; b_pend = 0;
        clr_a();
        test_reset();
        test_basic();
        test_order();
        test_backpressure();
        test_abort();
        test_start_busy();
        test_random();
        test_reset_mid();
        test_single();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mandel_frame_sequencer.md
Name: mandel_frame_sequencer

Overview:
- Parametrised successor to the single-engine pixel state machine in the tiny-mandelbrot top level.
- Schedules a full WIDTH x HEIGHT frame across NUM_ENGINES mandelbrot engines: dispatches pixel coordinates round-robin, captures each engine's iteration count, and retires results strictly in raster order on a valid/ready pixel stream.
- Sits between the serial configuration register (start/abort) and the framebuffer writer (pixel stream, reset_write_ptr).

Parameters:
NUM_ENGINES, 2, number of engine slots (1..8)
CTRWIDTH, 10, iteration-count width
WIDTH, 400, pixels per line
HEIGHT, 300, lines per frame
XW, $clog2(WIDTH), x coordinate width (derived, localparam)
YW, $clog2(HEIGHT), y coordinate width (derived, localparam)

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
start  in  1  one-cycle pulse; begins a frame when idle, ignored otherwise
abort  in  1  one-cycle pulse; cancels the frame
eng_run  out  NUM_ENGINES  one-hot, one-cycle dispatch pulse per engine
eng_x  out  XW  coordinate bus, valid with eng_run
eng_y  out  YW  coordinate bus, valid with eng_run
eng_running  in  NUM_ENGINES  per-engine busy flag
eng_ctr  in  NUM_ENGINES*CTRWIDTH  per-engine result; slice i = engine i
px_valid  out  1  pixel stream valid
px_ready  in  1  pixel stream ready
px_ctr  out  CTRWIDTH  iteration count
px_x  out  XW  pixel x
px_y  out  YW  pixel y
px_last  out  1  final pixel of frame, qualified by px_valid
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after last pixel handshake
reset_write_ptr  out  1  one-cycle pulse at frame start

Behaviour:
- Reset: all outputs 0; FSM IDLE; all slots FREE; dptr=rptr=0; counters 0.
- FSM states IDLE, CLEAR, RUN, DONE.
  - IDLE: start -> CLEAR.
  - CLEAR: reset_write_ptr=1 for exactly this cycle; clear coordinate/retire counters -> RUN.
  - RUN: dispatch and retire run concurrently; the handshake on the pixel with px_last=1 -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- abort in any non-IDLE state -> IDLE next cycle; all slots FREE, no further eng_run; px_valid drops; no frame_done. Engines are left to finish and their results are discarded. start is ignored in the abort cycle.
- Engine contract: the engine asserts running the cycle after eng_run; its result is valid on the running 1->0 edge, detected from a registered copy of eng_running per engine.
- Slot state per engine: FREE, BUSY, HELD.
- Dispatch (RUN only, at most one per cycle):
  - Condition: slot[dptr]==FREE and dispatch count < WIDTH*HEIGHT.
  - Pulse eng_run[dptr]; drive eng_x/eng_y with the next raster coordinate; latch those coordinates into slot dptr.
  - Slot -> BUSY; dptr wraps NUM_ENGINES-1 -> 0.
  - Raster advance: x++, wrapping at WIDTH-1 to 0 with y++.
- Capture: on the falling edge of slot i's running flag while BUSY, latch eng_ctr slice i into hold[i]; slot -> HELD.
- Retire:
  - px_valid = (state==RUN) && slot[rptr]==HELD.
  - px_ctr/px_x/px_y are driven from slot rptr.
  - On px_valid && px_ready: slot -> FREE; rptr wraps.
  - px_last = px_valid && px_x==WIDTH-1 && px_y==HEIGHT-1.
- Backpressure: while px_ready=0, px_valid and the data stay stable; HELD slots block redispatch; other engines may finish and hold.
- Simultaneous events:
  - A slot freed by retire is not redispatched in the same cycle (dispatch reads registered slot state); earliest redispatch is the next cycle.
  - Capture and retire on different slots in the same cycle are both honoured.
- Output order is always raster order, regardless of engine completion order.
- A running falling edge on a FREE or HELD slot is ignored.
- NUM_ENGINES=1 degenerates to strictly sequential dispatch/retire.
- Reset mid-frame: immediate async return to the reset state.

Test Plan:
- NUM_ENGINES=2, WIDTH=4, HEIGHT=2; start pulse, engines return ctr=x+4*y after 3 cycles, px_ready=1:
  - reset_write_ptr pulses once, one cycle after start.
  - 8 pixels emitted with (x,y) = (0,0)..(3,1) and ctr 0..7.
  - px_last only on (3,1); frame_done one cycle after that handshake; busy falls with it.
- Same frame, engine 1 latency 2 and engine 0 latency 9: px stream is still in raster order; engine 1 is redispatched only after its pixel retires.
- px_ready held 0 for 20 cycles mid-frame: px_valid/px_x/px_y/px_ctr stay stable; eng_run stops once both slots are HELD; the stream resumes losslessly.
- abort during RUN with 2 slots BUSY: IDLE next cycle; no px_valid, frame_done, or eng_run afterwards. A new start produces a complete frame from (0,0).
- start while busy: ignored, no second reset_write_ptr. Reset asserted mid-frame: all outputs 0 within the same cycle (async).
- NUM_ENGINES=1, WIDTH=3, HEIGHT=1: eng_run pulses only after each prior pixel handshake; 3 pixels then frame_done.
